// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, lock status and timing errors from HSync/VSync.
// Define VGA_DECODE_MEASURE_EN to add the measured line/frame length outputs o_HTotal/o_VTotal.
module vga_sync_decoder #(
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int H_ACTIVE_START = 144,
  parameter int H_VISIBLE      = 640,
  parameter int V_ACTIVE_START = 35,
  parameter int V_VISIBLE      = 480,
  parameter bit SYNC_ACTIVE    = 1'b0,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_HSync,
  input  logic        i_VSync,
  output logic [9:0]  o_X,
  output logic [9:0]  o_Y,
  output logic        o_Active,
  output logic        o_Locked,
  output logic        o_FrameStart,
  output logic        o_Error
`ifdef VGA_DECODE_MEASURE_EN
  ,
  output logic [10:0] o_HTotal,
  output logic [9:0]  o_VTotal
`endif
);

  localparam logic [11:0] H_END       = 12'(H_TOTAL);
  localparam logic [11:0] H_LO        = 12'(H_ACTIVE_START);
  localparam logic [11:0] H_HI        = 12'(H_ACTIVE_START + H_VISIBLE);
  localparam logic [10:0] V_END       = 11'(V_TOTAL);
  localparam logic [10:0] V_LO        = 11'(V_ACTIVE_START);
  localparam logic [10:0] V_HI        = 11'(V_ACTIVE_START + V_VISIBLE);
  localparam logic [3:0]  GOOD_TARGET = 4'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX       = 11'h7ff;

  typedef enum logic [1:0] {SEARCH, ALIGN, CHECK, LOCKED} state_t;

  state_t      state_reg;
  logic        hs_reg, vs_reg;
  logic        frame_pending_reg;
  logic        first_clk_reg;
  logic [10:0] h_reg;
  logic [9:0]  v_reg;
  logic [3:0]  good_reg;

  logic        hs_edge, vs_edge, frame_line, checking;
  logic        timeout, line_bad, frame_bad, violation, in_area;
  logic [11:0] h_ext, h_inc;
  logic [10:0] v_ext, v_inc;
  logic [10:0] x_full;
  logic [9:0]  y_full;
  logic [3:0]  good_inc;

  always_comb begin
    hs_edge    = (i_HSync == SYNC_ACTIVE) && (hs_reg != SYNC_ACTIVE);
    vs_edge    = (i_VSync == SYNC_ACTIVE) && (vs_reg != SYNC_ACTIVE);
    h_ext      = {1'b0, h_reg};
    h_inc      = h_ext + 12'd1;
    v_ext      = {1'b0, v_reg};
    v_inc      = v_ext + 11'd1;
    checking   = (state_reg == CHECK) || (state_reg == LOCKED);
    // A VSync edge seen since the last line (or right now) makes this line the frame's first.
    frame_line = hs_edge && (frame_pending_reg || vs_edge);
    timeout    = (h_reg == H_MAX);
    line_bad   = hs_edge && (h_inc != H_END);
    // The alignment edge itself is not measured: v has no valid reference before it.
    frame_bad  = frame_line && checking && (v_inc != V_END);
    violation  = (state_reg != SEARCH) && (timeout || line_bad || frame_bad);
    in_area    = (state_reg == LOCKED) && (h_ext >= H_LO) && (h_ext < H_HI) &&
                 (v_ext >= V_LO) && (v_ext < V_HI);
    x_full     = h_reg - H_LO[10:0];
    y_full     = v_reg - V_LO[9:0];
    good_inc   = good_reg + 4'd1;
  end

  always_ff @(posedge i_Clk) begin
    hs_reg <= i_HSync;
    vs_reg <= i_VSync;
    if (i_Reset) begin
      state_reg         <= SEARCH;
      h_reg             <= '0;
      v_reg             <= '0;
      good_reg          <= '0;
      frame_pending_reg <= 1'b0;
      first_clk_reg     <= 1'b0;
      o_X               <= '0;
      o_Y               <= '0;
      o_Active          <= 1'b0;
      o_Locked          <= 1'b0;
      o_FrameStart      <= 1'b0;
      o_Error           <= 1'b0;
`ifdef VGA_DECODE_MEASURE_EN
      o_HTotal          <= '0;
      o_VTotal          <= '0;
`endif
    end else begin
      o_Active      <= in_area;
      o_X           <= in_area ? x_full[9:0] : 10'd0;
      o_Y           <= in_area ? y_full : 10'd0;
      o_Error       <= violation && checking;
      // Suppressed when a violation lands in the same cycle so the pulses never overlap.
      o_FrameStart  <= first_clk_reg && (state_reg == LOCKED) && !violation;
      first_clk_reg <= frame_line && !violation;
`ifdef VGA_DECODE_MEASURE_EN
      if (hs_edge)    o_HTotal <= h_inc[10:0];
      if (frame_line) o_VTotal <= v_inc[9:0];
`endif
      if (violation) begin
        state_reg         <= SEARCH;
        h_reg             <= '0;
        v_reg             <= '0;
        good_reg          <= '0;
        frame_pending_reg <= 1'b0;
        o_Locked          <= 1'b0;
      end else begin
        if (hs_edge)             h_reg <= '0;
        else if (h_reg != H_MAX) h_reg <= h_reg + 11'd1;

        if (hs_edge) begin
          v_reg             <= frame_line ? 10'd0 : v_reg + 10'd1;
          frame_pending_reg <= 1'b0;
        end else if (vs_edge) begin
          frame_pending_reg <= 1'b1;
        end

        case (state_reg)
          SEARCH: if (hs_edge) state_reg <= ALIGN;
          ALIGN: begin
            if (frame_line) begin
              state_reg <= CHECK;
              good_reg  <= '0;
            end
          end
          CHECK: begin
            if (frame_line) begin
              good_reg <= good_inc;
              if (good_inc == GOOD_TARGET) begin
                state_reg <= LOCKED;
                o_Locked  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
